mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 3: memory access latency in cycles, legal range 1..7.
REQ-002 SHALL have parameter MD_TIMEOUT, default 40: maximum mult/div wait in cycles before a fault, legal range 2..255.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports opcode  in  6, and funct  in  6: instruction fields [31:26] and [5:0].
REQ-006 SHALL have ports overflow, div_zero, md_done  in  1 each: ALU overflow, divisor zero, mult/div complete.
REQ-007 SHALL have outputs pc_write, ir_write, a_write, b_write, aluout_write, mem_write, reg_write, epc_write  out  1 each: register and memory write enables.
REQ-008 SHALL have outputs md_start  out  1 (one-cycle start pulse) and md_sel  out  1 (0 = mult, 1 = div).
REQ-009 SHALL have outputs mem_addr_sel  out  3, alu_src_a  out  2, alu_src_b  out  3, alu_op  out  3, pc_src  out  2, reg_dst  out  2, wdata_sel  out  3: datapath mux selects.
REQ-010 SHALL have outputs exc_cause  out  2 (00 opcode, 01 overflow, 10 div-by-zero, 11 md timeout), halted  out  1, and state_dbg  out  5 (current state code).

Function
REQ-011 States SHALL be RESET_INIT, FETCH, DECODE, EXEC_R, EXEC_I, MEM_RD, MEM_WR, WB, BRANCH, JUMP, MD_WAIT, EXC, HALT.
REQ-012 Write enables SHALL be decoded from the state (Moore outputs); each is high only in its own state, and is 0 in every other state.
REQ-013 FETCH SHALL hold ir_write=1, mem_addr_sel=010, alu_op=001 (add), and alu_src_b=001 (+4) for exactly MEM_WAIT cycles; pc_write=1 is asserted in the final cycle only, then the FSM goes to DECODE.
REQ-014 DECODE SHALL assert a_write=b_write=1, compute the branch target into ALUOut (alu_src_b=010), and dispatch on opcode/funct in one cycle.
REQ-015 An unsupported opcode or funct SHALL go to EXC with exc_cause=00.
REQ-016 EXEC_R/EXEC_I SHALL assert aluout_write, then go to WB, MEM_RD or MEM_WR; if overflow=1 during add/addi, the FSM SHALL go to EXC with exc_cause=01 and no reg_write.
REQ-017 MEM_RD and MEM_WR SHALL each last MEM_WAIT cycles; mem_write is high in every MEM_WR cycle; MEM_RD ends in WB with wdata_sel=001.
REQ-018 mult/div: md_start SHALL pulse for exactly one cycle on entry to MD_WAIT; the FSM stays in MD_WAIT until md_done=1, then goes to FETCH.
REQ-019 div with div_zero=1 SHALL go to EXC with exc_cause=10 and no md_start.
REQ-020 If MD_WAIT lasts MD_TIMEOUT cycles without md_done, the FSM SHALL go to EXC with exc_cause=11; an md_done arriving in that same cycle wins.
REQ-021 BRANCH (beq/bne/ble/bgt) SHALL take one cycle, assert pc_write only when the condition holds, and use pc_src=01.
REQ-022 JUMP (j/jal/jr) SHALL take one cycle; jal also asserts reg_write with reg_dst=10 (r31) and wdata_sel=010 (PC).
REQ-023 EXC SHALL take one cycle: epc_write=1 (PC-4), pc_src=11 (exception vector), pc_write=1, then FETCH; exc_cause holds until the next EXC.
REQ-024 break SHALL enter HALT with halted=1; the FSM stays in HALT until reset.
REQ-025 The wait counter SHALL be sized clog2(max(MEM_WAIT, MD_TIMEOUT)+1), clear on every state change, and never wrap.

Reset
REQ-026 Asserting reset (low) SHALL immediately force state RESET_INIT, clear the counter, all write enables, md_start and halted, and set all selects and exc_cause to 0, including mid-FETCH or mid-MD_WAIT.
REQ-027 RESET_INIT SHALL last one cycle with reg_write=1, reg_dst=01 and wdata_sel=011 (stack-pointer init), then go to FETCH.

Structure
REQ-028 Opcode, funct, state codes, alu_op codes and exc_cause codes SHALL live in a shared package, mc_ctrl_pkg.
REQ-029 Opcode/funct dispatch SHALL be a combinational sub-module, mc_ctrl_decode, that outputs the next state class and an illegal flag.

Verification
REQ-030 Reset released, MEM_WAIT=3 -> RESET_INIT for 1 cycle, FETCH for 3 cycles with pc_write only in cycle 3, then DECODE.
REQ-031 add with overflow=1 in EXEC_R -> EXC, exc_cause=01, epc_write=1, reg_write never 1.
REQ-032 mult, md_done after 5 cycles -> one md_start pulse, 5 MD_WAIT cycles, then FETCH; with MD_TIMEOUT=4 -> EXC, exc_cause=11.
REQ-033 opcode=6'b111111 -> EXC with exc_cause=00; break -> halted=1 held for 100 cycles.
REQ-034 reset asserted in FETCH cycle 2 -> all enables 0 asynchronously, before the next clk edge.
REQ-035 lw with MEM_WAIT=1 and MEM_WAIT=7 -> MEM_RD lasts 1 and 7 cycles respectively, WB with wdata_sel=001.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, FSM
// state codes, ALU operations, exception causes and datapath mux selects.
package mc_ctrl_pkg;

    // Instruction opcodes (bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLE   = 6'b000110;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (bits [5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_BREAK = 6'b001101;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // FSM state codes, visible on state_dbg
    typedef enum logic [4:0] {
        ST_RESET_INIT = 5'd0,
        ST_FETCH      = 5'd1,
        ST_DECODE     = 5'd2,
        ST_EXEC_R     = 5'd3,
        ST_EXEC_I     = 5'd4,
        ST_MEM_RD     = 5'd5,
        ST_MEM_WR     = 5'd6,
        ST_WB         = 5'd7,
        ST_BRANCH     = 5'd8,
        ST_JUMP       = 5'd9,
        ST_MD_WAIT    = 5'd10,
        ST_EXC        = 5'd11,
        ST_HALT       = 5'd12
    } state_e;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_MD, CLS_BRK, CLS_ILL
    } cls_e;

    typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LE, BR_GT} br_e;
    typedef enum logic [1:0] {JMP_J, JMP_JAL, JMP_JR} jmp_e;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Exception causes
    localparam logic [1:0] EXC_OPCODE = 2'b00;
    localparam logic [1:0] EXC_OVF    = 2'b01;
    localparam logic [1:0] EXC_DIVZ   = 2'b10;
    localparam logic [1:0] EXC_MDTO   = 2'b11;

    // Datapath mux selects
    localparam logic [2:0] MADDR_ALUOUT = 3'b001;
    localparam logic [2:0] MADDR_PC     = 3'b010;
    localparam logic [1:0] SRCA_PC      = 2'b00;
    localparam logic [1:0] SRCA_A       = 2'b01;
    localparam logic [2:0] SRCB_B       = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_BOFF    = 3'b010;
    localparam logic [2:0] SRCB_IMM     = 3'b011;
    localparam logic [2:0] SRCB_ZERO    = 3'b100;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;
    localparam logic [1:0] REGDST_RT    = 2'b00;
    localparam logic [1:0] REGDST_SP    = 2'b01;
    localparam logic [1:0] REGDST_RA    = 2'b10;
    localparam logic [1:0] REGDST_RD    = 2'b11;
    localparam logic [2:0] WDATA_ALUOUT = 3'b000;
    localparam logic [2:0] WDATA_MEM    = 3'b001;
    localparam logic [2:0] WDATA_PC     = 3'b010;
    localparam logic [2:0] WDATA_SPINIT = 3'b011;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct dispatch: instruction class, illegal flag and
// the per-instruction ALU/branch/jump details the FSM needs later on.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output cls_e       cls_o,
    output logic       illegal_o,
    output logic [2:0] alu_op_o,
    output logic       ovf_chk_o,
    output logic       md_div_o,
    output br_e        br_type_o,
    output jmp_e       jmp_type_o
);

    // Classify the instruction; anything not listed falls through as illegal
    always_comb begin
        cls_o      = CLS_ILL;
        alu_op_o   = ALU_ADD;
        ovf_chk_o  = 1'b0;
        md_div_o   = 1'b0;
        br_type_o  = BR_EQ;
        jmp_type_o = JMP_J;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:   begin cls_o = CLS_R; ovf_chk_o = 1'b1; end
                    FN_SUB:   begin cls_o = CLS_R; alu_op_o = ALU_SUB; end
                    FN_AND:   begin cls_o = CLS_R; alu_op_o = ALU_AND; end
                    FN_OR:    begin cls_o = CLS_R; alu_op_o = ALU_OR;  end
                    FN_SLT:   begin cls_o = CLS_R; alu_op_o = ALU_SLT; end
                    FN_MULT:  cls_o = CLS_MD;
                    FN_DIV:   begin cls_o = CLS_MD; md_div_o = 1'b1; end
                    FN_JR:    begin cls_o = CLS_J; jmp_type_o = JMP_JR; end
                    FN_BREAK: cls_o = CLS_BRK;
                    default:  cls_o = CLS_ILL;
                endcase
            end
            OP_ADDI: begin cls_o = CLS_I; ovf_chk_o = 1'b1; end
            OP_ANDI: begin cls_o = CLS_I; alu_op_o = ALU_AND; end
            OP_ORI:  begin cls_o = CLS_I; alu_op_o = ALU_OR;  end
            OP_SLTI: begin cls_o = CLS_I; alu_op_o = ALU_SLT; end
            OP_LW:   cls_o = CLS_LW;
            OP_SW:   cls_o = CLS_SW;
            OP_BEQ:  begin cls_o = CLS_BR; alu_op_o = ALU_SUB; br_type_o = BR_EQ; end
            OP_BNE:  begin cls_o = CLS_BR; alu_op_o = ALU_SUB; br_type_o = BR_NE; end
            OP_BLE:  begin cls_o = CLS_BR; alu_op_o = ALU_SUB; br_type_o = BR_LE; end
            OP_BGT:  begin cls_o = CLS_BR; alu_op_o = ALU_SUB; br_type_o = BR_GT; end
            OP_J:    begin cls_o = CLS_J; jmp_type_o = JMP_J;   end
            OP_JAL:  begin cls_o = CLS_J; jmp_type_o = JMP_JAL; end
            default: cls_o = CLS_ILL;
        endcase
        illegal_o = (cls_o == CLS_ILL);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control FSM. Moore outputs decoded from the current state;
// every output is forced inactive while reset is held low. Branch conditions
// come from the ALU flags alu_zero/alu_neg of the A-B compare in BRANCH.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT   = 3,
    parameter int MD_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       md_done,
    input  logic       alu_zero,
    input  logic       alu_neg,
    output logic       pc_write,
    output logic       ir_write,
    output logic       a_write,
    output logic       b_write,
    output logic       aluout_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       epc_write,
    output logic       md_start,
    output logic       md_sel,
    output logic [2:0] mem_addr_sel,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [2:0] wdata_sel,
    output logic [1:0] exc_cause,
    output logic       halted,
    output logic [4:0] state_dbg
);

    localparam int CNT_MAX = max_int(MEM_WAIT, MD_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_WAIT - 1);
    localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;

    cls_e       dec_cls;
    logic       dec_illegal;
    logic [2:0] dec_alu_op;
    logic       dec_ovf_chk;
    logic       dec_md_div;
    br_e        dec_br;
    jmp_e       dec_jmp;
    logic       br_taken;

    mc_ctrl_decode u_decode (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .cls_o      (dec_cls),
        .illegal_o  (dec_illegal),
        .alu_op_o   (dec_alu_op),
        .ovf_chk_o  (dec_ovf_chk),
        .md_div_o   (dec_md_div),
        .br_type_o  (dec_br),
        .jmp_type_o (dec_jmp)
    );

    // State, wait counter and latched exception cause
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET_INIT;
            cnt_q   <= '0;
            cause_q <= EXC_OPCODE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Branch condition from the A-B compare flags
    always_comb begin
        case (dec_br)
            BR_EQ:   br_taken = alu_zero;
            BR_NE:   br_taken = !alu_zero;
            BR_LE:   br_taken = alu_zero || alu_neg;
            default: br_taken = !(alu_zero || alu_neg);
        endcase
    end

    // Next-state logic; the cause register only changes on the way into EXC
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_RESET_INIT: state_d = ST_FETCH;
            ST_FETCH:      if (cnt_q == MEM_LAST) state_d = ST_DECODE;
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d = ST_EXC;
                    cause_d = EXC_OPCODE;
                end else begin
                    case (dec_cls)
                        CLS_R:   state_d = ST_EXEC_R;
                        CLS_BR:  state_d = ST_BRANCH;
                        CLS_J:   state_d = ST_JUMP;
                        CLS_BRK: state_d = ST_HALT;
                        CLS_MD: begin
                            if (dec_md_div && div_zero) begin
                                state_d = ST_EXC;
                                cause_d = EXC_DIVZ;
                            end else begin
                                state_d = ST_MD_WAIT;
                            end
                        end
                        default: state_d = ST_EXEC_I;
                    endcase
                end
            end
            ST_EXEC_R, ST_EXEC_I: begin
                if (dec_cls == CLS_LW) begin
                    state_d = ST_MEM_RD;
                end else if (dec_cls == CLS_SW) begin
                    state_d = ST_MEM_WR;
                end else if (dec_ovf_chk && overflow) begin
                    state_d = ST_EXC;
                    cause_d = EXC_OVF;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM_RD:     if (cnt_q == MEM_LAST) state_d = ST_WB;
            ST_MEM_WR:     if (cnt_q == MEM_LAST) state_d = ST_FETCH;
            ST_WB, ST_BRANCH, ST_JUMP, ST_EXC: state_d = ST_FETCH;
            ST_MD_WAIT: begin
                // completion takes priority over a timeout in the same cycle
                if (md_done) begin
                    state_d = ST_FETCH;
                end else if (cnt_q == MD_LAST) begin
                    state_d = ST_EXC;
                    cause_d = EXC_MDTO;
                end
            end
            ST_HALT:       state_d = ST_HALT;
            default:       state_d = ST_RESET_INIT;
        endcase
    end

    // Wait counter: restarts on every state change, saturates instead of wrapping
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Moore outputs; all held inactive while reset is asserted
    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        a_write      = 1'b0;
        b_write      = 1'b0;
        aluout_write = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        epc_write    = 1'b0;
        md_start     = 1'b0;
        md_sel       = 1'b0;
        mem_addr_sel = 3'b000;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_B;
        alu_op       = 3'b000;
        pc_src       = PCSRC_ALU;
        reg_dst      = REGDST_RT;
        wdata_sel    = WDATA_ALUOUT;
        halted       = 1'b0;
        exc_cause    = cause_q;
        state_dbg    = state_q;
        if (reset) begin
            case (state_q)
                ST_RESET_INIT: begin
                    reg_write = 1'b1;
                    reg_dst   = REGDST_SP;
                    wdata_sel = WDATA_SPINIT;
                end
                ST_FETCH: begin
                    ir_write     = 1'b1;
                    mem_addr_sel = MADDR_PC;
                    alu_src_a    = SRCA_PC;
                    alu_src_b    = SRCB_FOUR;
                    alu_op       = ALU_ADD;
                    pc_src       = PCSRC_ALU;
                    pc_write     = (cnt_q == MEM_LAST);
                end
                ST_DECODE: begin
                    a_write      = 1'b1;
                    b_write      = 1'b1;
                    aluout_write = 1'b1;
                    alu_src_a    = SRCA_PC;
                    alu_src_b    = SRCB_BOFF;
                    alu_op       = ALU_ADD;
                end
                ST_EXEC_R: begin
                    aluout_write = 1'b1;
                    alu_src_a    = SRCA_A;
                    alu_src_b    = SRCB_B;
                    alu_op       = dec_alu_op;
                end
                ST_EXEC_I: begin
                    aluout_write = 1'b1;
                    alu_src_a    = SRCA_A;
                    alu_src_b    = SRCB_IMM;
                    alu_op       = dec_alu_op;
                end
                ST_MEM_RD: mem_addr_sel = MADDR_ALUOUT;
                ST_MEM_WR: begin
                    mem_addr_sel = MADDR_ALUOUT;
                    mem_write    = 1'b1;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    if (dec_cls == CLS_LW) begin
                        reg_dst   = REGDST_RT;
                        wdata_sel = WDATA_MEM;
                    end else if (dec_cls == CLS_R) begin
                        reg_dst   = REGDST_RD;
                        wdata_sel = WDATA_ALUOUT;
                    end else begin
                        reg_dst   = REGDST_RT;
                        wdata_sel = WDATA_ALUOUT;
                    end
                end
                ST_BRANCH: begin
                    alu_src_a = SRCA_A;
                    alu_src_b = SRCB_B;
                    alu_op    = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = br_taken;
                end
                ST_JUMP: begin
                    pc_write = 1'b1;
                    if (dec_jmp == JMP_JR) begin
                        // jr target is A + 0 straight off the ALU
                        alu_src_a = SRCA_A;
                        alu_src_b = SRCB_ZERO;
                        alu_op    = ALU_ADD;
                        pc_src    = PCSRC_ALU;
                    end else begin
                        pc_src = PCSRC_JUMP;
                    end
                    if (dec_jmp == JMP_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = REGDST_RA;
                        wdata_sel = WDATA_PC;
                    end
                end
                ST_MD_WAIT: begin
                    md_start = (cnt_q == '0);
                    md_sel   = dec_md_div;
                end
                ST_EXC: begin
                    // EPC gets PC-4, PC gets the exception vector
                    epc_write = 1'b1;
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_SUB;
                    pc_src    = PCSRC_EXC;
                    pc_write  = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: three instances with different MEM_WAIT /
// MD_TIMEOUT, each released from reset in turn while the others stay reset.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [5:0] opcode, funct;
    logic       overflow, div_zero, md_done, alu_zero, alu_neg;

    logic       pc_write [3];
    logic       ir_write [3];
    logic       a_write [3];
    logic       b_write [3];
    logic       aluout_write [3];
    logic       mem_write [3];
    logic       reg_write [3];
    logic       epc_write [3];
    logic       md_start [3];
    logic       md_sel [3];
    logic [2:0] mem_addr_sel [3];
    logic [1:0] alu_src_a [3];
    logic [2:0] alu_src_b [3];
    logic [2:0] alu_op [3];
    logic [1:0] pc_src [3];
    logic [1:0] reg_dst [3];
    logic [2:0] wdata_sel [3];
    logic [1:0] exc_cause [3];
    logic       halted [3];
    logic [4:0] state_dbg [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // instance 0: defaults; 1: MEM_WAIT=1, MD_TIMEOUT=4; 2: MEM_WAIT=7
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mc_ctrl_fsm #(
            .MEM_WAIT   ((gi == 1) ? 1 : (gi == 2) ? 7 : 3),
            .MD_TIMEOUT ((gi == 1) ? 4 : 40)
        ) u_dut (
            .clk          (clk),
            .reset        (rst_n[gi]),
            .opcode       (opcode),
            .funct        (funct),
            .overflow     (overflow),
            .div_zero     (div_zero),
            .md_done      (md_done),
            .alu_zero     (alu_zero),
            .alu_neg      (alu_neg),
            .pc_write     (pc_write[gi]),
            .ir_write     (ir_write[gi]),
            .a_write      (a_write[gi]),
            .b_write      (b_write[gi]),
            .aluout_write (aluout_write[gi]),
            .mem_write    (mem_write[gi]),
            .reg_write    (reg_write[gi]),
            .epc_write    (epc_write[gi]),
            .md_start     (md_start[gi]),
            .md_sel       (md_sel[gi]),
            .mem_addr_sel (mem_addr_sel[gi]),
            .alu_src_a    (alu_src_a[gi]),
            .alu_src_b    (alu_src_b[gi]),
            .alu_op       (alu_op[gi]),
            .pc_src       (pc_src[gi]),
            .reg_dst      (reg_dst[gi]),
            .wdata_sel    (wdata_sel[gi]),
            .exc_cause    (exc_cause[gi]),
            .halted       (halted[gi]),
            .state_dbg    (state_dbg[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // From the state before FETCH, step through all FETCH cycles into DECODE
    task automatic run_fetch(input int k, input int mw);
        for (int c = 1; c <= mw; c++) begin
            cyc();
            chk("fetch_state", state_dbg[k], 32'd1);
            chk("fetch_pc_write", pc_write[k], (c == mw) ? 32'd1 : 32'd0);
        end
        cyc();
        chk("decode_state", state_dbg[k], 32'd2);
        $display("inst%0d fetch %0d cycles -> DECODE", k, mw);
    endtask

    // Full lw path: FETCH, DECODE, EXEC_I, MEM_RD x mw, WB
    task automatic lw_path(input int k, input int mw);
        opcode = 6'b100011;
        funct  = 6'b000000;
        run_fetch(k, mw);
        cyc();
        chk("lw_exec_i", state_dbg[k], 32'd4);
        for (int c = 1; c <= mw; c++) begin
            cyc();
            chk("lw_mem_rd", state_dbg[k], 32'd5);
        end
        cyc();
        chk("lw_wb_state", state_dbg[k], 32'd7);
        chk("lw_wb_wdata", wdata_sel[k], 32'd1);
        chk("lw_wb_reg_write", reg_write[k], 32'd1);
        $display("inst%0d lw MEM_RD %0d cycles -> WB", k, mw);
    endtask

    initial begin
        int pulses;
        int hold;
        rst_n    = 3'b000;
        opcode   = 6'd0;
        funct    = 6'd0;
        overflow = 1'b0;
        div_zero = 1'b0;
        md_done  = 1'b0;
        alu_zero = 1'b0;
        alu_neg  = 1'b0;
        #1;
        chk("rst_state", state_dbg[0], 32'd0);
        chk("rst_reg_write", reg_write[0], 32'd0);
        chk("rst_ir_write", ir_write[0], 32'd0);
        chk("rst_exc_cause", exc_cause[0], 32'd0);
        $display("reset state checked");

        // add with overflow -> EXC cause 01
        opcode   = 6'b000000;
        funct    = 6'b100000;
        overflow = 1'b1;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        #1;
        chk("init_state", state_dbg[0], 32'd0);
        chk("init_reg_write", reg_write[0], 32'd1);
        chk("init_reg_dst", reg_dst[0], 32'd1);
        chk("init_wdata", wdata_sel[0], 32'd3);
        run_fetch(0, 3);
        chk("decode_ab_write", {a_write[0], b_write[0]}, 32'd3);
        chk("decode_src_b", alu_src_b[0], 32'd2);
        cyc();
        chk("add_exec_r", state_dbg[0], 32'd3);
        chk("add_aluout_write", aluout_write[0], 32'd1);
        chk("add_exec_reg_write", reg_write[0], 32'd0);
        cyc();
        chk("ovf_exc_state", state_dbg[0], 32'd11);
        chk("ovf_exc_cause", exc_cause[0], 32'd1);
        chk("ovf_epc_write", epc_write[0], 32'd1);
        chk("ovf_pc_src", pc_src[0], 32'd3);
        chk("ovf_reg_write", reg_write[0], 32'd0);
        $display("add overflow -> EXC cause=%0d", exc_cause[0]);
        overflow = 1'b0;

        // illegal opcode -> EXC cause 00
        opcode = 6'b111111;
        run_fetch(0, 3);
        cyc();
        chk("ill_exc_state", state_dbg[0], 32'd11);
        chk("ill_exc_cause", exc_cause[0], 32'd0);
        $display("illegal opcode -> EXC cause=%0d", exc_cause[0]);

        // mult with md_done in the 5th MD_WAIT cycle
        opcode = 6'b000000;
        funct  = 6'b011000;
        run_fetch(0, 3);
        pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("mult_md_wait", state_dbg[0], 32'd10);
            if (md_start[0] === 1'b1) pulses++;
            if (i == 5) md_done = 1'b1;
        end
        chk("mult_md_start_pulses", pulses, 32'd1);
        $display("mult: 5 MD_WAIT cycles, md_start pulses=%0d", pulses);

        // div by zero -> EXC cause 10, no md_start
        funct    = 6'b011010;
        div_zero = 1'b1;
        run_fetch(0, 3);
        md_done = 1'b0;
        cyc();
        chk("divz_exc_state", state_dbg[0], 32'd11);
        chk("divz_exc_cause", exc_cause[0], 32'd2);
        chk("divz_md_start", md_start[0], 32'd0);
        $display("div by zero -> EXC cause=%0d", exc_cause[0]);
        div_zero = 1'b0;

        // branches
        opcode   = 6'b000100;
        alu_zero = 1'b1;
        run_fetch(0, 3);
        cyc();
        chk("beq_state", state_dbg[0], 32'd8);
        chk("beq_taken_pc_write", pc_write[0], 32'd1);
        chk("beq_pc_src", pc_src[0], 32'd1);
        $display("beq zero=1 pc_write=%0d", pc_write[0]);
        opcode = 6'b000101;
        run_fetch(0, 3);
        cyc();
        chk("bne_not_taken", pc_write[0], 32'd0);
        $display("bne zero=1 pc_write=%0d", pc_write[0]);
        opcode   = 6'b000111;
        alu_zero = 1'b0;
        alu_neg  = 1'b1;
        run_fetch(0, 3);
        cyc();
        chk("bgt_neg_not_taken", pc_write[0], 32'd0);
        $display("bgt neg=1 pc_write=%0d", pc_write[0]);
        alu_neg = 1'b0;

        // jal
        opcode = 6'b000011;
        run_fetch(0, 3);
        cyc();
        chk("jal_state", state_dbg[0], 32'd9);
        chk("jal_reg_write", reg_write[0], 32'd1);
        chk("jal_reg_dst", reg_dst[0], 32'd2);
        chk("jal_wdata", wdata_sel[0], 32'd2);
        chk("jal_pc_write", pc_write[0], 32'd1);
        $display("jal reg_dst=%0d wdata_sel=%0d", reg_dst[0], wdata_sel[0]);

        lw_path(0, 3);

        // break -> HALT held for 100 cycles
        opcode = 6'b000000;
        funct  = 6'b001101;
        run_fetch(0, 3);
        cyc();
        chk("brk_halted", halted[0], 32'd1);
        hold = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (halted[0] === 1'b1 && state_dbg[0] === 5'd12) hold++;
        end
        chk("brk_hold_100", hold, 32'd100);
        $display("break: halted held %0d cycles", hold);
        rst_n[0] = 1'b0;
        #1;
        chk("halt_reset_halted", halted[0], 32'd0);

        // asynchronous reset in FETCH cycle 2
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        cyc();
        cyc();
        chk("fetch2_state", state_dbg[0], 32'd1);
        #3;
        rst_n[0] = 1'b0;
        #1;
        chk("async_rst_state", state_dbg[0], 32'd0);
        chk("async_rst_enables",
            {pc_write[0], ir_write[0], a_write[0], b_write[0], aluout_write[0],
             mem_write[0], reg_write[0], epc_write[0], md_start[0]}, 32'd0);
        chk("async_rst_maddr", mem_addr_sel[0], 32'd0);
        $display("reset mid-FETCH cleared enables");

        // instance 1: MEM_WAIT=1, MD_TIMEOUT=4
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        #1;
        chk("i1_init_state", state_dbg[1], 32'd0);
        lw_path(1, 1);
        opcode  = 6'b000000;
        funct   = 6'b011000;
        md_done = 1'b0;
        run_fetch(1, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("i1_md_wait", state_dbg[1], 32'd10);
        end
        cyc();
        chk("i1_mdto_state", state_dbg[1], 32'd11);
        chk("i1_mdto_cause", exc_cause[1], 32'd3);
        $display("inst1 md timeout -> EXC cause=%0d", exc_cause[1]);
        rst_n[1] = 1'b0;

        // instance 2: MEM_WAIT=7
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        lw_path(2, 7);
        rst_n[2] = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
